// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: word width, opcode field, and the NOP/HALT encodings
// used by fetch, decode and the IF/ID buffer.
package fetch_stage_pkg;

  localparam int WORD_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam word_t   NOP_INSTR = 16'h0000;
  localparam opcode_t HALT_OP   = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic opcode_t opcode_of(input word_t instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and registers the
// fetched word and its PC for the IF/ID buffer. Handles stall, redirect and HALT.
module fetch_stage #(
  parameter fetch_stage_pkg::word_t   RESET_PC  = 16'h0000,
  parameter fetch_stage_pkg::word_t   NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
  parameter fetch_stage_pkg::opcode_t HALT_OP   = fetch_stage_pkg::HALT_OP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  fetch_stage_pkg::word_t redirect_pc,
  output fetch_stage_pkg::word_t imem_addr,
  input  fetch_stage_pkg::word_t imem_data,
  output fetch_stage_pkg::word_t instr_out,
  output fetch_stage_pkg::word_t pc_out,
  output logic                   valid_out,
  output logic                   halted
);
  import fetch_stage_pkg::*;

  fetch_state_e state;
  word_t        pc;

  logic fetched_halt;

  assign imem_addr    = pc;
  assign fetched_halt = (opcode_of(imem_data) == HALT_OP);

  // Priority: rst > redirect > stall > state action. A redirect also leaves HALT,
  // and pc_out keeps the last real instruction's PC while the bubble goes out.
  // NOTE: all state here is sequential, so every assignment is non-blocking to avoid
  // read/write ordering races between registers updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      instr_out <= NOP_INSTR;
      pc_out    <= '0;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      state     <= ST_RUN;
      pc        <= redirect_pc;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
      halted    <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        ST_RUN: begin
          instr_out <= imem_data;
          pc_out    <= pc;
          valid_out <= 1'b1;
          // The HALT word itself is passed on; the PC parks on it.
          if (fetched_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc + word_t'(1);
          end
        end
        ST_HALT: begin
          instr_out <= NOP_INSTR;
          valid_out <= 1'b0;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle stimulus with hand-derived
// expected outputs, routed through a scoreboard queue and compared after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word = 16'h1000 + address, except a HALT at address 7.
  always_comb begin
    imem_data = 16'h1000 + imem_addr;
    if (imem_addr == 16'h0007) imem_data = 16'hF000;
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input string name, input logic r, input logic s, input logic d,
                     input logic [15:0] rpc, input logic [15:0] instr,
                     input logic [15:0] pc, input logic v, input logic h,
                     input logic [15:0] addr);
    vec_t t;
    t.name = name; t.rst = r; t.stall = s; t.redir = d; t.rpc = rpc;
    t.instr = instr; t.pc = pc; t.valid = v; t.halted = h; t.addr = addr;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus, record expectations, then compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.name, ".instr_out"}, instr_out, e.instr);
    check({e.name, ".pc_out"},    pc_out,    e.pc);
    check({e.name, ".valid_out"}, {15'b0, valid_out}, {15'b0, e.valid});
    check({e.name, ".halted"},    {15'b0, halted},    {15'b0, e.halted});
    check({e.name, ".imem_addr"}, imem_addr, e.addr);
  endtask

  initial begin
    //  name        rst stl rdr rpc       instr     pc_out   v  h  addr
    add("reset",    1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    add("run0",     0, 0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 0, 16'h0001);
    add("run1",     0, 0, 0, 16'h0000, 16'h1001, 16'h0001, 1, 0, 16'h0002);
    add("run2",     0, 0, 0, 16'h0000, 16'h1002, 16'h0002, 1, 0, 16'h0003);
    add("stall1",   0, 1, 0, 16'h0000, 16'h1002, 16'h0002, 1, 0, 16'h0003);
    add("stall2",   0, 1, 0, 16'h0000, 16'h1002, 16'h0002, 1, 0, 16'h0003);
    add("resume3",  0, 0, 0, 16'h0000, 16'h1003, 16'h0003, 1, 0, 16'h0004);
    add("run4",     0, 0, 0, 16'h0000, 16'h1004, 16'h0004, 1, 0, 16'h0005);
    add("redir_st", 0, 1, 1, 16'h0040, 16'h0000, 16'h0004, 0, 0, 16'h0040);
    add("tgt40",    0, 0, 0, 16'h0000, 16'h1040, 16'h0040, 1, 0, 16'h0041);
    add("redir5",   0, 0, 1, 16'h0005, 16'h0000, 16'h0040, 0, 0, 16'h0005);
    add("run5",     0, 0, 0, 16'h0000, 16'h1005, 16'h0005, 1, 0, 16'h0006);
    add("run6",     0, 0, 0, 16'h0000, 16'h1006, 16'h0006, 1, 0, 16'h0007);
    add("halt_in",  0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 1, 1, 16'h0007);
    for (int i = 0; i < 5; i++)
      add("halted",  0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 1, 16'h0007);
    add("halt_stl", 0, 1, 0, 16'h0000, 16'h0000, 16'h0007, 0, 1, 16'h0007);
    add("exit_hlt", 0, 0, 1, 16'h0010, 16'h0000, 16'h0007, 0, 0, 16'h0010);
    add("run10",    0, 0, 0, 16'h0000, 16'h1010, 16'h0010, 1, 0, 16'h0011);
    add("redirFE",  0, 0, 1, 16'hFFFE, 16'h0000, 16'h0010, 0, 0, 16'hFFFE);
    add("wrapFE",   0, 0, 0, 16'h0000, 16'h0FFE, 16'hFFFE, 1, 0, 16'hFFFF);
    add("wrapFF",   0, 0, 0, 16'h0000, 16'h0FFF, 16'hFFFF, 1, 0, 16'h0000);
    add("wrap00",   0, 0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 0, 16'h0001);
    add("wrap01",   0, 0, 0, 16'h0000, 16'h1001, 16'h0001, 1, 0, 16'h0002);
    add("redir_h",  0, 0, 1, 16'h0007, 16'h0000, 16'h0001, 0, 0, 16'h0007);
    add("halt_tgt", 0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 1, 1, 16'h0007);
    add("hstall",   0, 1, 0, 16'h0000, 16'hF000, 16'h0007, 1, 1, 16'h0007);
    add("rst_h_st", 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    add("post_rst", 0, 0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 0, 16'h0001);

    foreach (vecs[i]) step(vecs[i]);

    // Hand-written corner: reset beats a simultaneous redirect, then a redirect
    // beats a stall while halted and fetch picks up at the target.
    begin
      vec_t t;
      t = '{"rst_vs_rd", 1, 0, 1, 16'h0055, 16'h0000, 16'h0000, 0, 0, 16'h0000};
      step(t);
      t = '{"run_a",     0, 0, 0, 16'h0000, 16'h1000, 16'h0000, 1, 0, 16'h0001};
      step(t);
      t = '{"to_halt",   0, 0, 1, 16'h0007, 16'h0000, 16'h0000, 0, 0, 16'h0007};
      step(t);
      t = '{"halt_b",    0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 1, 1, 16'h0007};
      step(t);
      t = '{"hbubble",   0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 1, 16'h0007};
      step(t);
      t = '{"rd_st_h",   0, 1, 1, 16'h0020, 16'h0000, 16'h0007, 0, 0, 16'h0020};
      step(t);
      t = '{"run20",     0, 0, 0, 16'h0000, 16'h1020, 16'h0020, 1, 0, 16'h0021};
      step(t);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline buffer and drives its instruction input.
- Owns the program counter.
- Addresses instruction memory and registers the fetched 16-bit instruction and its PC for the IF/ID buffer.
- Honours stall and branch-redirect requests from later stages.
- Stops fetching on a HALT instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, instruction word emitted as a bubble
HALT_OP, 4'hF, opcode value (instr[15:12]) that halts fetch

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit request: hold PC and all outputs
redirect  input  1  branch/jump resolved taken: load redirect_pc and flush
redirect_pc  input  16  target PC for redirect
imem_addr  output  16  instruction memory word address (combinational from PC register)
imem_data  input  16  instruction memory read data, combinational w.r.t. imem_addr
instr_out  output  16  registered instruction to the IF/ID buffer instruction input
pc_out  output  16  registered PC of instr_out
valid_out  output  1  instr_out is a real instruction (0 = bubble)
halted  output  1  fetch is stopped in HALT state

Behaviour:
- State machine has two states: RUN and HALT. One register holds the state; pc is a 16-bit register. imem_addr = pc at all times.
- Priority each rising edge: rst > redirect > stall > normal state action.
- On rst=1:
  - pc <= RESET_PC, instr_out <= NOP_INSTR, pc_out <= 16'h0000.
  - valid_out <= 0, halted <= 0, state <= RUN.
  - These values appear the cycle after rst is sampled high. Reset asserted mid-operation (including in HALT) behaves identically.
- On redirect=1:
  - pc <= redirect_pc, instr_out <= NOP_INSTR, valid_out <= 0, pc_out holds.
  - state <= RUN, halted <= 0.
  - The one-cycle bubble flushes the wrong-path fetch. Redirect overrides stall and also exits HALT.
- On stall=1 (no redirect): pc, instr_out, pc_out, valid_out, state and halted all hold their values.
- RUN, no stall, no redirect:
  - instr_out <= imem_data, pc_out <= pc, valid_out <= 1.
  - If imem_data[15:12] != HALT_OP: pc <= pc + 1, a 16-bit add that wraps 16'hFFFF -> 16'h0000.
  - If imem_data[15:12] == HALT_OP: the HALT word is still passed on with valid_out <= 1. pc holds (not incremented), state <= HALT, halted <= 1.
- HALT, no stall, no redirect: instr_out <= NOP_INSTR, valid_out <= 0, pc and pc_out hold, halted stays 1.
- Latency is one cycle from imem_data sampled at address pc to instr_out. Throughput is one instruction per unstalled cycle.
- Redirect and stall in the same cycle: redirect wins, no hold.
- A redirect whose target holds a HALT word: the bubble is emitted first; HALT is fetched and taken on the next unstalled cycle.

Decomposition:
- Shared pipeline package holds:
  - WORD_W = 16
  - OPCODE field position [15:12]
  - the NOP_INSTR and HALT_OP constants, shared with the decode stage and IF/ID buffer.
- No sub-module is needed.
- The PC next-value mux (reset / redirect / hold / +1) may be a function or a tiny pc_next_mux sub-module; use a single file otherwise.

Test Plan:
- Reset then free-run: rst=1 one cycle, then rst=0 with imem returning 16'h1000+addr -> instr_out 16'h1000,16'h1001,16'h1002 with pc_out 0,1,2; valid_out=1 from first post-reset edge; rst value check instr_out=0, valid_out=0.
- Stall: at pc=3 assert stall 2 cycles -> imem_addr stays 3, instr_out/pc_out/valid_out unchanged 2 cycles; on release fetch resumes at 3 with no loss or duplicate.
- Redirect with simultaneous stall: at pc=5 assert redirect=1, stall=1, redirect_pc=16'h0040 -> next cycle valid_out=0, instr_out=16'h0000, imem_addr=16'h0040; following cycle instr_out=mem[0x40], pc_out=16'h0040.
- HALT: mem[7]=16'hF000 -> instr_out=16'hF000 with valid_out=1, then halted=1, valid_out=0, instr_out=16'h0000, imem_addr stays 7 for 5+ cycles; redirect to 16'h0010 clears halted and resumes fetch.
- PC wrap: redirect_pc=16'hFFFE, no stalls -> pc_out sequence FFFE, FFFF, 0000, 0001.
- Reset mid-HALT and mid-stall: rst=1 while halted=1 and stall=1 -> next cycle halted=0, valid_out=0, imem_addr=RESET_PC.
